// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared definitions for the bit-serial subtractor.
//   DEFAULT_WIDTH : default operand/result width
//   state_t       : controller states (IDLE, SHIFT, DONE)
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_sub_if.sv
// serial_sub_if: request/response handshake bundle of the serial subtractor.
//   req_valid/req_ready : operand handshake, carries a (minuend), b (subtrahend)
//   rsp_valid/rsp_ready : result handshake, carries diff, borrow, ovf
//   master : producer of operands / consumer of results
//   slave  : the subtractor itself
interface serial_sub_if #(
    parameter int WIDTH = serial_sub_pkg::DEFAULT_WIDTH
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             ovf;

    modport master (
        output req_valid, a, b, rsp_ready,
        input  req_ready, rsp_valid, diff, borrow, ovf
    );

    modport slave (
        input  req_valid, a, b, rsp_ready,
        output req_ready, rsp_valid, diff, borrow, ovf
    );
endinterface

// File: rtl/fulladder.sv
// fulladder: single-bit full adder cell.
//   i_a, i_b, i_c : addend bits and carry-in
//   o_sum, o_c    : sum bit and carry-out
module fulladder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_sum,
    output logic o_c
);
    assign o_sum = i_a ^ i_b ^ i_c;
    assign o_c   = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

// File: rtl/serial_sub_core.sv
// serial_sub_core: LSB-first bit-serial subtractor computing a + ~b + 1
// through a single full adder cell.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of serial_sub_if (operands in, result out)
module serial_sub_core
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    serial_sub_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             sum;
    logic             cout;

    logic             ready;
    logic             valid;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             ovf;

    fulladder u_fa (
        .i_a   (a_reg[0]),
        .i_b   (~b_reg[0]),
        .i_c   (carry),
        .o_sum (sum),
        .o_c   (cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ready  <= 1'b1;
            valid  <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
            ovf    <= 1'b0;
            carry  <= 1'b0;
            cnt    <= '0;
            a_reg  <= '0;
            b_reg  <= '0;
            res    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        a_reg <= bus.a;
                        b_reg <= bus.b;
                        carry <= 1'b1;   // +1 of the two's-complement negation
                        cnt   <= '0;
                        res   <= '0;
                        ready <= 1'b0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_reg <= a_reg >> 1;
                    b_reg <= b_reg >> 1;
                    res   <= {sum, res[WIDTH-1:1]};
                    carry <= cout;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        // MSB cell: carry is its carry-in, cout its carry-out
                        diff   <= {sum, res[WIDTH-1:1]};
                        borrow <= ~cout;
                        ovf    <= carry ^ cout;
                        valid  <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        valid <= 1'b0;
                        ready <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    ready <= 1'b1;
                    valid <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = ready;
    assign bus.rsp_valid = valid;
    assign bus.diff      = diff;
    assign bus.borrow    = borrow;
    assign bus.ovf       = ovf;
endmodule

// File: rtl/serial_sub.sv
// serial_sub: bit-serial subtractor, o_diff = i_a - i_b mod 2^WIDTH, with
// unsigned borrow and signed overflow flags; one result per WIDTH+2 cycles.
//   i_clk, i_rst       : clock, synchronous active-high reset
//   i_valid, o_ready   : operand handshake, operands i_a (minuend), i_b
//   o_valid, i_ready   : result handshake, results o_diff, o_borrow, o_ovf
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_borrow,
    output logic             o_ovf
);
    serial_sub_if #(.WIDTH(WIDTH)) bus ();

    assign bus.req_valid = i_valid;
    assign bus.a         = i_a;
    assign bus.b         = i_b;
    assign bus.rsp_ready = i_ready;
    assign o_ready       = bus.req_ready;
    assign o_valid       = bus.rsp_valid;
    assign o_diff        = bus.diff;
    assign o_borrow      = bus.borrow;
    assign o_ovf         = bus.ovf;

    serial_sub_core #(.WIDTH(WIDTH)) u_core (
        .clk (i_clk),
        .rst (i_rst),
        .bus (bus.slave)
    );
endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: self-checking bench for serial_sub at WIDTH=8 with a
// plain-arithmetic reference model.
module tb_serial_sub;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    serial_sub_if #(.WIDTH(W)) bus ();

    serial_sub #(.WIDTH(W)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_valid  (bus.req_valid),
        .o_ready  (bus.req_ready),
        .i_a      (bus.a),
        .i_b      (bus.b),
        .o_valid  (bus.rsp_valid),
        .i_ready  (bus.rsp_ready),
        .o_diff   (bus.diff),
        .o_borrow (bus.borrow),
        .o_ovf    (bus.ovf)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [W-1:0] ref_diff(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] d;
        d = a - b;
        return d;
    endfunction

    function automatic logic ref_borrow(input logic [W-1:0] a, input logic [W-1:0] b);
        return int'(a) < int'(b);
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b);
        int sa, sb, r;
        sa = int'($signed(a));
        sb = int'($signed(b));
        r  = sa - sb;
        return (r > (2 ** (W - 1)) - 1) || (r < -(2 ** (W - 1)));
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        bus.a = '0;
        bus.b = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.diff !== '0 ||
            bus.borrow !== 1'b0 || bus.ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: ready=%b valid=%b diff=%h borrow=%b ovf=%b, want 1 0 00 0 0",
                     bus.req_ready, bus.rsp_valid, bus.diff, bus.borrow, bus.ovf);
        end
    endtask

    // Accepts one request and waits for the result; leaves the DUT in DONE
    // with i_ready=0. Returns the edge count (accept edge counted as 1).
    task automatic start_and_wait(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input string name, output int n);
        checks++;
        if (bus.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_ready_idle: o_ready=%b want 1", name, bus.req_ready);
        end
        bus.req_valid = 1'b1;
        bus.a = a;
        bus.b = b;
        @(posedge clk);
        #1;
        n = 1;
        // Operands and i_valid/i_ready are don't-care while shifting.
        while (n < 40) begin
            bus.req_valid = 1'($urandom_range(0, 1));
            bus.a = W'($urandom);
            bus.b = W'($urandom);
            bus.rsp_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            bus.rsp_ready = 1'b0;
            bus.req_valid = 1'b0;
            n++;
            if (bus.rsp_valid === 1'b1) break;
        end
        checks++;
        if (n !== W + 1) begin
            failures++;
            $display("FAIL %s_latency: edges=%0d want %0d", name, n, W + 1);
        end
    endtask

    task automatic check_result(input logic [W-1:0] a, input logic [W-1:0] b, input string name);
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.diff !== ref_diff(a, b) ||
            bus.borrow !== ref_borrow(a, b) || bus.ovf !== ref_ovf(a, b)) begin
            failures++;
            $display("FAIL %s_result a=%h b=%h: valid=%b diff=%h borrow=%b ovf=%b, want 1 %h %b %b",
                     name, a, b, bus.rsp_valid, bus.diff, bus.borrow, bus.ovf,
                     ref_diff(a, b), ref_borrow(a, b), ref_ovf(a, b));
        end
    endtask

    task automatic release_result(input string name);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        checks++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s_release: ready=%b valid=%b want 1 0", name, bus.req_ready, bus.rsp_valid);
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input string name);
        int n;
        start_and_wait(a, b, name, n);
        check_result(a, b, name);
        release_result(name);
    endtask

    task automatic test_directed();
        run_op(8'h05, 8'h03, "d_05_03");
        run_op(8'h00, 8'h01, "d_00_01");
        run_op(8'h80, 8'h01, "d_80_01");
        run_op(8'h7F, 8'hFF, "d_7F_FF");
        run_op(8'h5A, 8'h5A, "d_equal");
        run_op(8'hFF, 8'h00, "d_FF_00");
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            run_op(W'($urandom), W'($urandom), "rand");
        end
    endtask

    task automatic test_backpressure();
        int n;
        logic [W-1:0] a, b;
        a = 8'hC3;
        b = 8'h3C;
        start_and_wait(a, b, "bp", n);
        for (int k = 0; k < 5; k++) begin
            bus.req_valid = 1'($urandom_range(0, 1));
            bus.a = W'($urandom);
            bus.b = W'($urandom);
            @(posedge clk);
            #1;
            bus.req_valid = 1'b0;
            check_result(a, b, "bp_hold");
            checks++;
            if (bus.req_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_ready_low: o_ready=%b want 0", bus.req_ready);
            end
        end
        release_result("bp");
    endtask

    task automatic test_reset_mid_op();
        bus.req_valid = 1'b1;
        bus.a = 8'hAA;
        bus.b = 8'h11;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        bus.req_valid = 1'b1;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        checks++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.diff !== '0) begin
            failures++;
            $display("FAIL mid_reset: ready=%b valid=%b diff=%h want 1 0 00",
                     bus.req_ready, bus.rsp_valid, bus.diff);
        end
        run_op(8'h10, 8'h10, "after_reset");
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] qa[3], qb[3];
        logic [W-1:0] got_d[$];
        logic         got_bo[$];
        logic         got_ov[$];
        int           acc_cyc[$];
        int           accepts;
        logic         prev_ready;
        for (int i = 0; i < 3; i++) begin
            qa[i] = W'($urandom);
            qb[i] = W'($urandom);
        end
        accepts = 0;
        prev_ready = bus.req_ready;
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1;
        bus.a = qa[0];
        bus.b = qb[0];
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(posedge clk);
            #1;
            if (prev_ready && accepts < 3) begin
                acc_cyc.push_back(cyc);
                accepts++;
                if (accepts < 3) begin
                    bus.a = qa[accepts];
                    bus.b = qb[accepts];
                end else begin
                    bus.req_valid = 1'b0;
                end
            end
            if (bus.rsp_valid === 1'b1) begin
                got_d.push_back(bus.diff);
                got_bo.push_back(bus.borrow);
                got_ov.push_back(bus.ovf);
            end
            prev_ready = bus.req_ready;
            if (got_d.size() == 3) break;
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        checks++;
        if (got_d.size() != 3 || acc_cyc.size() != 3) begin
            failures++;
            $display("FAIL b2b_count: results=%0d accepts=%0d want 3 3", got_d.size(), acc_cyc.size());
        end else begin
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (acc_cyc[i] - acc_cyc[i-1] != W + 2) begin
                    failures++;
                    $display("FAIL b2b_spacing[%0d]: %0d cycles want %0d", i,
                             acc_cyc[i] - acc_cyc[i-1], W + 2);
                end
            end
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got_d[i] !== ref_diff(qa[i], qb[i]) || got_bo[i] !== ref_borrow(qa[i], qb[i]) ||
                    got_ov[i] !== ref_ovf(qa[i], qb[i])) begin
                    failures++;
                    $display("FAIL b2b_result[%0d]: diff=%h borrow=%b ovf=%b want %h %b %b", i,
                             got_d[i], got_bo[i], got_ov[i], ref_diff(qa[i], qb[i]),
                             ref_borrow(qa[i], qb[i]), ref_ovf(qa[i], qb[i]));
                end
            end
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, want finish before 200000");
        $fatal(1);
    end
endmodule

// File: doc/serial_sub.md
SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand/result width in bits, legal range 2..32.
REQ-002 SHALL have port i_clk  input  1  rising-edge clock, sole clock of the block.
REQ-003 SHALL have port i_rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port i_valid  input  1  operand request valid.
REQ-005 SHALL have port o_ready  output  1  block can accept operands.
REQ-006 SHALL have port i_a  input  WIDTH  minuend.
REQ-007 SHALL have port i_b  input  WIDTH  subtrahend.
REQ-008 SHALL have port o_valid  output  1  result valid.
REQ-009 SHALL have port i_ready  input  1  result consumer ready.
REQ-010 SHALL have port o_diff  output  WIDTH  i_a - i_b, modulo 2^WIDTH.
REQ-011 SHALL have port o_borrow  output  1  unsigned borrow, i.e. i_a < i_b.
REQ-012 SHALL have port o_ovf  output  1  two's-complement overflow of the signed subtraction.

Function
REQ-013 SHALL implement the FSM states IDLE, SHIFT and DONE.
REQ-014 SHALL assert o_ready only in IDLE.
REQ-015 SHALL, in IDLE when i_valid=1, capture i_a and i_b, load the carry register with 1, clear the bit counter and go to SHIFT.
REQ-016 SHALL, in SHIFT, process one bit per cycle, LSB first: cell inputs a[k], ~b[k] and carry; sum shifts into the result register MSB; carry_out loads the carry register.
REQ-017 SHALL stay in SHIFT for exactly WIDTH cycles, then go to DONE.
REQ-018 SHALL set the following on DONE entry: o_borrow = ~carry after the MSB; o_ovf = carry-in XOR carry-out of the MSB bit; o_diff = result register.
REQ-019 SHALL give a latency of WIDTH+1 cycles from the accept edge to o_valid=1.
REQ-020 SHALL hold o_valid=1 in DONE, with o_diff, o_borrow and o_ovf stable, until i_ready=1.
REQ-021 SHALL, on the DONE edge where i_ready=1, return to IDLE; o_ready=1 in the next cycle, so there is no same-cycle accept.
REQ-022 SHALL ignore i_valid, i_a and i_b outside IDLE; operands are not re-sampled mid-operation.
REQ-023 SHALL ignore i_ready outside DONE.
REQ-024 SHALL size the bit counter as $clog2(WIDTH)+1 bits; the count never wraps within an operation.
REQ-025 SHALL treat equal operands as a normal case: o_diff=0, o_borrow=0, o_ovf=0.

Reset
REQ-026 SHALL, while i_rst=1 at a clock edge, enter IDLE from any state, including mid-SHIFT and DONE; the in-flight operation is discarded.
REQ-027 SHALL give reset values: o_ready=1 from the cycle after reset, o_valid=0, o_diff=0, o_borrow=0, o_ovf=0, carry=0, counter=0.
REQ-028 SHALL give i_rst priority over i_valid and i_ready in the same cycle.

Structure
REQ-029 SHALL place the FSM state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and the default WIDTH in the shared package serial_sub_pkg.
REQ-030 SHALL instantiate the existing single-bit fulladder exactly once as the datapath cell, connected through ports o_sum, o_c, i_a, i_b and i_c, with i_b driven by the inverted subtrahend bit.
REQ-031 SHALL contain no '-' arithmetic operator in the datapath; all subtraction is done through the fulladder cell.

Verification
REQ-032 SHALL cover, at WIDTH=8: a=0x05, b=0x03 -> o_valid at accept+9, o_diff=0x02, borrow=0, ovf=0.
REQ-033 SHALL cover: a=0x00, b=0x01 -> o_diff=0xFF, borrow=1, ovf=0.
REQ-034 SHALL cover: a=0x80, b=0x01 -> o_diff=0x7F, borrow=0, ovf=1; then a=0x7F, b=0xFF -> o_diff=0x80, borrow=1, ovf=1.
REQ-035 SHALL cover backpressure: i_ready=0 for 5 cycles after o_valid -> outputs stay constant, o_ready=0; after i_ready=1, o_ready=1 on the next cycle.
REQ-036 SHALL cover reset mid-operation: i_rst=1 at the 4th SHIFT cycle -> next cycle o_ready=1, o_valid=0; then a fresh 0x10-0x10 request -> o_diff=0x00, borrow=0.
REQ-037 SHALL cover back-to-back traffic: i_valid held at 1 with i_ready tied to 1 for 3 requests -> one accept per 10 cycles, no lost or duplicated results.
